fc_core_ctrl: RTL and testbench

Sequencer for the 8-bit fully-connected MAC core. On a start pulse it clears the core and streams N node/weight pairs from two single-port read memories (node buffer, weight buffer) into the core. It counts the core's output-valid pulses and captures the final accumulated dot product. It sits between the host-side control registers and the FC core, one controller per core instance.

---
 rtl/fc_core_ctrl.sv | 81 ++++++++
 tb/tb_fc_core_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fc_core_ctrl.sv
// fc_core_ctrl: sequences node/weight reads into the FC MAC core and captures the final dot product.
module fc_core_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_start,
  input  logic [CNT_WIDTH-1:0]    i_num_node,
  output logic [CNT_WIDTH-1:0]    o_node_addr,
  output logic [CNT_WIDTH-1:0]    o_wegt_addr,
  output logic                    o_node_ce,
  output logic                    o_wegt_ce,
  input  logic [DATA_WIDTH-1:0]   i_node_data,
  input  logic [DATA_WIDTH-1:0]   i_wegt_data,
  output logic                    o_core_run,
  output logic                    o_core_valid,
  output logic [DATA_WIDTH-1:0]   o_core_node,
  output logic [DATA_WIDTH-1:0]   o_core_wegt,
  input  logic                    i_core_valid,
  input  logic [4*DATA_WIDTH-1:0] i_core_result,
  output logic                    o_idle,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*DATA_WIDTH-1:0] o_result
);
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] num, issue_cnt, ret_cnt;
  logic [4*DATA_WIDTH-1:0] result;
  logic core_valid, ce, ret_en, last_ret;
  assign ce       = state == FETCH;
  assign ret_en   = (state == FETCH || state == DRAIN) && i_core_valid;
  assign last_ret = ret_en && ret_cnt == num - 1'b1;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_start ? CLEAR : IDLE;
      CLEAR:   state_nx = num == '0 ? DONE : FETCH;
      FETCH:   state_nx = issue_cnt == num - 1'b1 ? DRAIN : FETCH;
      DRAIN:   state_nx = (last_ret || ret_cnt == num) ? DONE : DRAIN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      num        <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      result     <= '0;
      core_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      core_valid <= ce;
      if (state == IDLE && i_start) num <= i_num_node;
      if (state == CLEAR) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
        result    <= '0;
      end else begin
        if (ce) issue_cnt <= issue_cnt + 1'b1;
        if (ret_en) ret_cnt <= ret_cnt + 1'b1;
        if (last_ret) result <= i_core_result;
      end
    end
  end
  assign o_node_addr  = ce ? issue_cnt : '0;
  assign o_wegt_addr  = ce ? issue_cnt : '0;
  assign o_node_ce    = ce;
  assign o_wegt_ce    = ce;
  assign o_core_run   = state == CLEAR;
  assign o_core_valid = core_valid;
  assign o_core_node  = core_valid ? i_node_data : '0;
  assign o_core_wegt  = core_valid ? i_wegt_data : '0;
  assign o_idle       = state == IDLE;
  assign o_busy       = state != IDLE;
  assign o_done       = state == DONE;
  assign o_result     = result;
endmodule

// File: tb/tb_fc_core_ctrl.sv
// tb_fc_core_ctrl: directed and random runs of fc_core_ctrl against memory/core models and a dot-product reference.
module tb_fc_core_ctrl;
  localparam int DW = 8;
  localparam int CW = 10;
  logic clk = 1'b0, reset_n = 1'b1, i_start = 1'b0;
  logic [CW-1:0] i_num_node = '0;
  logic [CW-1:0] o_node_addr, o_wegt_addr;
  logic o_node_ce, o_wegt_ce, o_core_run, o_core_valid, o_idle, o_busy, o_done;
  logic [DW-1:0] o_core_node, o_core_wegt;
  logic [DW-1:0] node_q = '0, wegt_q = '0;
  logic [31:0] o_result, acc = '0, p1 = '0;
  logic v1 = 1'b0, v2 = 1'b0;
  logic [DW-1:0] node_mem [1024];
  logic [DW-1:0] wegt_mem [1024];
  int total = 0, bad = 0, cyc = 0;
  int ce_cnt = 0, cv_cnt = 0, done_cnt = 0, addr_err = 0, prot_err = 0;

  fc_core_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_num_node(i_num_node),
    .o_node_addr(o_node_addr), .o_wegt_addr(o_wegt_addr),
    .o_node_ce(o_node_ce), .o_wegt_ce(o_wegt_ce),
    .i_node_data(node_q), .i_wegt_data(wegt_q),
    .o_core_run(o_core_run), .o_core_valid(o_core_valid),
    .o_core_node(o_core_node), .o_core_wegt(o_core_wegt),
    .i_core_valid(v2), .i_core_result(acc),
    .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  always #5 clk = ~clk;

  // Memories with one-cycle read latency and a two-stage MAC core
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_node_ce) node_q <= node_mem[o_node_addr];
    if (o_wegt_ce) wegt_q <= wegt_mem[o_wegt_addr];
    v1 <= o_core_valid;
    p1 <= {24'b0, o_core_node} * {24'b0, o_core_wegt};
    v2 <= v1;
    if (o_core_run) acc <= '0;
    else if (v1) acc <= acc + p1;
  end

  always @(negedge clk) begin
    if (o_node_ce) begin
      if (o_node_addr != ce_cnt[CW-1:0]) addr_err++;
      ce_cnt++;
    end
    if (o_core_valid) cv_cnt++;
    if (o_done) done_cnt++;
    if (o_node_ce !== o_wegt_ce || o_node_addr !== o_wegt_addr || (o_core_run && o_core_valid) ||
        (!o_core_valid && (o_core_node != '0 || o_core_wegt != '0))) prot_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n, input bit now, input int rp, input string tag);
    int t0;
    logic [31:0] exp;
    exp = '0;
    for (int i = 0; i < n; i++) exp += {24'b0, node_mem[i]} * {24'b0, wegt_mem[i]};
    if (!now) @(negedge clk);
    ce_cnt = 0; cv_cnt = 0; done_cnt = 0; addr_err = 0; prot_err = 0;
    i_num_node = CW'(n);
    i_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, " clear"}, {31'b0, o_core_run}, 1);
    while (!o_done && cyc - t0 < n + 20) begin
      @(negedge clk);
      i_start = rp > 0 && cyc - t0 == rp;
    end
    i_start = 1'b0;
    check({tag, " done_cycle"}, cyc - t0, n == 0 ? 2 : n + 5);
    @(negedge clk);
    check({tag, " idle"}, {31'b0, o_idle}, 1);
    check({tag, " result"}, o_result, exp);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " reads"}, ce_cnt, n);
    check({tag, " core_valids"}, cv_cnt, n);
    check({tag, " addr_order"}, addr_err, 0);
    check({tag, " protocol"}, prot_err, 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("rst idle", {31'b0, o_idle}, 1);
    check("rst busy", {31'b0, o_busy}, 0);
    check("rst done", {31'b0, o_done}, 0);
    check("rst run", {31'b0, o_core_run}, 0);
    check("rst cvalid", {31'b0, o_core_valid}, 0);
    check("rst ce", {30'b0, o_node_ce, o_wegt_ce}, 0);
    check("rst addr", {12'b0, o_node_addr, o_wegt_addr}, 0);
    check("rst operands", {16'b0, o_core_node, o_core_wegt}, 0);
    check("rst result", o_result, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin node_mem[i] = DW'(i + 1); wegt_mem[i] = DW'(i + 5); end
    run(4, 0, 0, "n4");
    check("n4 held", o_result, 70);
    for (int i = 0; i < 16; i++) begin node_mem[i] = 8'hff; wegt_mem[i] = 8'hff; end
    run(16, 0, 0, "n16");
    run(0, 0, 0, "n0");

    for (int i = 0; i < 4; i++) begin node_mem[i] = DW'(i + 1); wegt_mem[i] = DW'(i + 5); end
    run(4, 0, 3, "repulse");
    for (int i = 0; i < 4; i++) wegt_mem[i] = 8'd1;
    run(4, 1, 0, "back2back");

    for (int i = 0; i < 8; i++) begin node_mem[i] = DW'($urandom); wegt_mem[i] = DW'($urandom); end
    @(negedge clk);
    done_cnt = 0;
    i_num_node = CW'(8);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst idle", {31'b0, o_idle}, 1);
    check("arst ce", {31'b0, o_node_ce}, 0);
    check("arst result", o_result, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("arst no_done", done_cnt, 0);
    node_mem[0] = 8'd3; node_mem[1] = 8'd4; wegt_mem[0] = 8'd2; wegt_mem[1] = 8'd2;
    run(2, 0, 0, "after_rst");
    reset_n = 1'b0;
    #1;
    check("idle_rst result", o_result, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin node_mem[i] = DW'($urandom); wegt_mem[i] = DW'($urandom); end
      run(n, r[0], 0, "rand");
    end

    for (int i = 0; i < 1023; i++) begin node_mem[i] = 8'd1; wegt_mem[i] = 8'd1; end
    run(1023, 0, 0, "nmax");
    check("nmax value", o_result, 1023);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
